// File: rtl/bar_uart_gpio_bridge.sv
// Host BAR register window: writable GPIO banks, SoC GPIO readback, and a FIFO-fed
// 8N1 serializer that drives the SoC UART RX pin.
module bar_uart_gpio_bridge #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                NUM_GPIO     = 2,
    parameter int                FIFO_DEPTH   = 16,
    parameter int                CLKS_PER_BIT = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 'h1000
) (
    input  logic                       clk_main_a0,
    input  logic                       rst_main_n,
    input  logic [ADDR_W-1:0]          pcie_bar_addr,
    input  logic [DATA_W-1:0]          pcie_bar_wdata,
    input  logic                       pcie_bar_wen,
    input  logic                       pcie_bar_ren,
    output logic [DATA_W-1:0]          pcie_bar_rdata,
    output logic                       pcie_bar_rvalid,
    output logic                       uart_rx_out,
    output logic [NUM_GPIO*DATA_W-1:0] gpio_in_out,
    input  logic [NUM_GPIO*DATA_W-1:0] gpio_out_in,
    input  logic [NUM_GPIO*DATA_W-1:0] gpio_oe_in,
    output logic                       irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;
    tx_state_t tx_state, tx_next;

    logic [ADDR_W-3:0] woff;
    logic              hit_tx, hit_st, hit_ctrl, gpio_sel, addr_ok, unused_addr_bits;
    logic              tx_enable, irq_en, overflow, bad_addr, tx_busy;
    logic              push, push_ok, pop, flush, fifo_full, fifo_empty, ovf_set, st_wr;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       fifo_count;
    logic [15:0]       level;
    logic [31:0]       status_word;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] gpio_in_q [NUM_GPIO];
    logic [CW-1:0]     clk_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic              bit_done;

    // Word offset into the window; an address below BASE_ADDR wraps to a large offset and decodes as bad.
    assign woff             = pcie_bar_addr[ADDR_W-1:2] - BASE_ADDR[ADDR_W-1:2];
    assign unused_addr_bits = ^pcie_bar_addr[1:0];
    assign hit_tx           = (woff == (ADDR_W - 2)'(0));
    assign hit_st           = (woff == (ADDR_W - 2)'(1));
    assign hit_ctrl         = (woff == (ADDR_W - 2)'(2));
    assign gpio_sel         = (woff[ADDR_W-3:6] == (ADDR_W - 8)'(1)) &&
                              (int'(woff[5:2]) < NUM_GPIO) && (woff[1:0] != 2'd3);
    assign addr_ok          = hit_tx | hit_st | hit_ctrl | gpio_sel;

    assign fifo_full  = (fifo_count == FULL_LVL);
    assign fifo_empty = (fifo_count == '0);
    assign level      = 16'(fifo_count);
    assign flush      = pcie_bar_wen && hit_ctrl && pcie_bar_wdata[1];
    assign push       = pcie_bar_wen && hit_tx;
    assign pop        = (tx_state == S_IDLE) && tx_enable && !fifo_empty && !flush;
    assign push_ok    = push && (!fifo_full || pop);
    assign ovf_set    = push && fifo_full && !pop;
    assign st_wr      = pcie_bar_wen && hit_st;
    assign bit_done   = (clk_cnt == BIT_LAST);

    assign status_word = {level, 6'd0, bad_addr, overflow, 5'd0, fifo_empty, fifo_full, tx_busy};

    always_comb begin
        rd_word = DATA_W'(32'hDEADBEEF);
        if (hit_tx) begin
            rd_word = DATA_W'(level);
        end else if (hit_st) begin
            rd_word = DATA_W'(status_word);
        end else if (hit_ctrl) begin
            rd_word = DATA_W'({29'd0, irq_en, 1'b0, tx_enable});
        end else if (gpio_sel) begin
            for (int i = 0; i < NUM_GPIO; i++) begin
                if (woff[5:2] == 4'(i)) begin
                    case (woff[1:0])
                        2'd0:    rd_word = gpio_in_q[i];
                        2'd1:    rd_word = gpio_out_in[i*DATA_W +: DATA_W];
                        default: rd_word = gpio_oe_in[i*DATA_W +: DATA_W];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_main_a0) begin
        if (!rst_main_n) begin
            tx_enable       <= 1'b0;
            irq_en          <= 1'b0;
            overflow        <= 1'b0;
            bad_addr        <= 1'b0;
            irq             <= 1'b0;
            pcie_bar_rdata  <= '0;
            pcie_bar_rvalid <= 1'b0;
            for (int i = 0; i < NUM_GPIO; i++) gpio_in_q[i] <= '0;
        end else begin
            if (pcie_bar_wen && hit_ctrl) begin
                tx_enable <= pcie_bar_wdata[0];
                irq_en    <= pcie_bar_wdata[2];
            end
            // A set event in the same cycle as a W1C keeps the bit set.
            overflow <= ovf_set | (overflow & ~(st_wr & pcie_bar_wdata[8]));
            bad_addr <= ((pcie_bar_wen | pcie_bar_ren) & ~addr_ok) |
                        (bad_addr & ~(st_wr & pcie_bar_wdata[9]));
            for (int i = 0; i < NUM_GPIO; i++) begin
                if (pcie_bar_wen && gpio_sel && woff[1:0] == 2'd0 && woff[5:2] == 4'(i))
                    gpio_in_q[i] <= pcie_bar_wdata;
            end
            pcie_bar_rvalid <= pcie_bar_ren;
            if (pcie_bar_ren) pcie_bar_rdata <= rd_word;
            irq <= irq_en & (overflow | bad_addr | (fifo_empty & ~tx_busy));
        end
    end

    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_gpio
        assign gpio_in_out[g*DATA_W +: DATA_W] = gpio_in_q[g];
    end

    always_ff @(posedge clk_main_a0) begin
        if (push_ok) mem[wr_ptr] <= pcie_bar_wdata[7:0];
    end

    always_ff @(posedge clk_main_a0) begin
        if (!rst_main_n || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk_main_a0) begin
        if (!rst_main_n) tx_state <= S_IDLE;
        else             tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (pop) tx_next = S_START;
            S_START: if (bit_done) tx_next = S_DATA;
            S_DATA:  if (bit_done && bit_idx == 3'd7) tx_next = S_STOP;
            default: if (bit_done) tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        uart_rx_out = 1'b1;
        tx_busy     = (tx_state != S_IDLE);
        case (tx_state)
            S_START: uart_rx_out = 1'b0;
            S_DATA:  uart_rx_out = shreg[0];
            default: uart_rx_out = 1'b1;
        endcase
    end

    // Bit timer restarts at every bit boundary and is held at zero while idle.
    always_ff @(posedge clk_main_a0) begin
        if (!rst_main_n) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (tx_state == S_IDLE || bit_done) clk_cnt <= '0;
            else                                clk_cnt <= clk_cnt + 1'b1;
            if (pop) begin
                shreg   <= mem[rd_ptr];
                bit_idx <= '0;
            end else if (tx_state == S_DATA && bit_done) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bar_uart_gpio_bridge.sv
// Directed bench for bar_uart_gpio_bridge: register table, UART framing, FIFO overflow,
// same-cycle access and mid-frame reset sequences.
module tb_bar_uart_gpio_bridge;
    localparam logic [31:0] A_TX   = 32'h1000;
    localparam logic [31:0] A_ST   = 32'h1004;
    localparam logic [31:0] A_CTRL = 32'h1008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        wen = 1'b0, ren = 1'b0, rvalid, line, irq;
    logic [63:0] gpio_in_out;
    logic [63:0] gpio_out_in = {32'h5555_1111, 32'hAAAA_0000};
    logic [63:0] gpio_oe_in  = {32'hF0F0_0000, 32'h0F0F_0F0F};
    int          n_pass = 0, n_total = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;
    vec_t vecs[31];

    always #5 clk = ~clk;

    bar_uart_gpio_bridge dut (
        .clk_main_a0(clk), .rst_main_n(rst_n),
        .pcie_bar_addr(addr), .pcie_bar_wdata(wdata),
        .pcie_bar_wen(wen), .pcie_bar_ren(ren),
        .pcie_bar_rdata(rdata), .pcie_bar_rvalid(rvalid),
        .uart_rx_out(line), .gpio_in_out(gpio_in_out),
        .gpio_out_in(gpio_out_in), .gpio_oe_in(gpio_oe_in), .irq(irq)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic bar_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic bar_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        check("rvalid", 64'(rvalid), 64'd1);
        d = rdata;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bar_read(a, d);
        check(name, 64'(d), 64'(exp));
    endtask

    // Counts cycles for which tx_busy stays at lvl, up to bound.
    task automatic run_length(input logic lvl, input int bound, output int n);
        n = 0;
        while (dut.tx_busy == lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_line_low(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (line !== 1'b0 && n < bound);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  byte_v;
        int          n, busy_n, low_n;

        vecs[0]  = '{1'b0, A_ST,          32'h0000_0004};
        vecs[1]  = '{1'b0, A_CTRL,        32'h0000_0000};
        vecs[2]  = '{1'b0, A_TX,          32'h0000_0000};
        vecs[3]  = '{1'b1, 32'h1110,      32'h1234_5678};
        vecs[4]  = '{1'b0, 32'h1110,      32'h1234_5678};
        vecs[5]  = '{1'b0, 32'h1114,      32'h5555_1111};
        vecs[6]  = '{1'b0, 32'h1118,      32'hF0F0_0000};
        vecs[7]  = '{1'b0, 32'h1104,      32'hAAAA_0000};
        vecs[8]  = '{1'b0, 32'h1108,      32'h0F0F_0F0F};
        vecs[9]  = '{1'b0, 32'h1116,      32'h5555_1111};
        vecs[10] = '{1'b1, 32'h1114,      32'hFFFF_FFFF};
        vecs[11] = '{1'b0, A_ST,          32'h0000_0004};
        vecs[12] = '{1'b0, 32'h1114,      32'h5555_1111};
        vecs[13] = '{1'b1, 32'h1100,      32'hCAFE_F00D};
        vecs[14] = '{1'b0, 32'h1100,      32'hCAFE_F00D};
        vecs[15] = '{1'b0, 32'h2000,      32'hDEAD_BEEF};
        vecs[16] = '{1'b0, A_ST,          32'h0000_0204};
        vecs[17] = '{1'b1, A_ST,          32'h0000_0200};
        vecs[18] = '{1'b0, A_ST,          32'h0000_0004};
        vecs[19] = '{1'b0, 32'h1120,      32'hDEAD_BEEF};
        vecs[20] = '{1'b1, A_ST,          32'h0000_0200};
        vecs[21] = '{1'b0, 32'h110C,      32'hDEAD_BEEF};
        vecs[22] = '{1'b1, A_ST,          32'h0000_0200};
        vecs[23] = '{1'b0, 32'h0FFC,      32'hDEAD_BEEF};
        vecs[24] = '{1'b1, 32'h3000,      32'h0000_0001};
        vecs[25] = '{1'b0, A_ST,          32'h0000_0204};
        vecs[26] = '{1'b1, A_ST,          32'h0000_0200};
        vecs[27] = '{1'b1, A_CTRL,        32'h0000_0007};
        vecs[28] = '{1'b0, A_CTRL,        32'h0000_0005};
        vecs[29] = '{1'b1, A_CTRL,        32'h0000_0000};
        vecs[30] = '{1'b0, A_ST,          32'h0000_0004};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset rdata", 64'(rdata), 64'd0);
        check("reset rvalid", 64'(rvalid), 64'd0);
        check("reset line", 64'(line), 64'd1);
        check("reset gpio_in_out", gpio_in_out, 64'd0);
        check("reset irq", 64'(irq), 64'd0);

        read_check("reset status", A_ST, 32'h0000_0004);
        @(negedge clk);
        check("rvalid one cycle", 64'(rvalid), 64'd0);
        check("rdata holds", 64'(rdata), 64'h4);

        for (int i = 0; i < 31; i++) begin
            if (vecs[i].wr) bar_write(vecs[i].addr, vecs[i].data);
            else read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data);
        end
        check("gpio banks", gpio_in_out, {32'h1234_5678, 32'hCAFE_F00D});
        check("irq off while disabled", 64'(irq), 64'd0);

        // Write and read of the same register in one cycle: read sees the old value.
        @(negedge clk);
        addr = 32'h1100; wdata = 32'h1111_2222; wen = 1'b1; ren = 1'b1;
        @(negedge clk);
        wen = 1'b0; ren = 1'b0;
        check("rw same cycle rvalid", 64'(rvalid), 64'd1);
        check("rw same cycle old", 64'(rdata), 64'hCAFE_F00D);
        check("rw same cycle gpio", 64'(gpio_in_out[31:0]), 64'h1111_2222);
        read_check("rw same cycle new", 32'h1100, 32'h1111_2222);

        // Single frame of 0xA5: start, 8 data bits LSB first, stop.
        byte_v = 8'hA5;
        bar_write(A_CTRL, 32'h1);
        bar_write(A_TX, 32'(byte_v));
        wait_line_low(5, n);
        check("pop to start bit", 64'(n), 64'd1);
        busy_n = 0;
        for (int j = 1; j <= 170; j++) begin
            if (j > 1) @(negedge clk);
            if (dut.tx_busy) busy_n++;
            if (j % 16 == 8 && j < 160) begin
                int idx;
                logic exp_bit;
                idx = (j - 1) / 16;
                if (idx == 0) exp_bit = 1'b0;
                else if (idx == 9) exp_bit = 1'b1;
                else exp_bit = byte_v[idx-1];
                check($sformatf("frame bit %0d", idx), 64'(line), 64'(exp_bit));
            end
        end
        check("busy cycles", 64'(busy_n), 64'd160);
        check("line idle after frame", 64'(line), 64'd1);

        // Two queued bytes: frames separated by exactly one idle cycle.
        bar_write(A_TX, 32'h0F);
        bar_write(A_TX, 32'hF0);
        run_length(1'b1, 400, n);
        run_length(1'b0, 10, n);
        check("inter-frame gap", 64'(n), 64'd1);
        run_length(1'b1, 400, n);
        check("second frame length", 64'(n), 64'd160);
        bar_write(A_CTRL, 32'h0);

        // Fill past full with irq enabled.
        bar_write(A_CTRL, 32'h4);
        @(negedge clk);
        check("irq empty idle", 64'(irq), 64'd1);
        for (int i = 0; i < 16; i++) bar_write(A_TX, 32'(i));
        read_check("status full", A_ST, 32'h0010_0002);
        check("irq full no error", 64'(irq), 64'd0);
        bar_write(A_TX, 32'h99);
        read_check("status overflow", A_ST, 32'h0010_0102);
        check("irq overflow", 64'(irq), 64'd1);
        read_check("level after drop", A_TX, 32'd16);
        bar_write(A_ST, 32'h100);
        read_check("overflow cleared", A_ST, 32'h0010_0002);
        check("irq after w1c", 64'(irq), 64'd0);
        bar_write(A_CTRL, 32'h6);
        read_check("status after flush", A_ST, 32'h0000_0004);
        read_check("ctrl flush self clears", A_CTRL, 32'h4);
        check("irq after flush", 64'(irq), 64'd1);
        bar_write(A_CTRL, 32'h0);

        // Reset in the middle of a frame.
        for (int i = 0; i < 3; i++) bar_write(A_TX, 32'h00);
        read_check("queued level", A_TX, 32'd3);
        bar_write(A_CTRL, 32'h1);
        repeat (30) @(negedge clk);
        check("line low mid frame", 64'(line), 64'd0);
        read_check("level mid frame", A_TX, 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("line high after reset", 64'(line), 64'd1);
        read_check("status after reset", A_ST, 32'h0000_0004);
        read_check("ctrl after reset", A_CTRL, 32'h0);
        low_n = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (line !== 1'b1 || dut.tx_busy) low_n++;
        end
        check("no frame while disabled", 64'(low_n), 64'd0);
        bar_write(A_CTRL, 32'h1);
        bar_write(A_TX, 32'h3C);
        wait_line_low(5, n);
        check("restart after enable", 64'(n), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
